// File: rtl/ab_pattern_gen_if.sv
// ab_pattern_gen_if: step-table write port, run control and pattern outputs of ab_pattern_gen
// master: drives wr_en/wr_addr/wr_data/wr_hold, len, start, abort, loop; observes a, b, busy, done, step_idx
// slave : the generator side of the same signals
interface ab_pattern_gen_if #(
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 4
);
    localparam int AW = $clog2(DEPTH);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [1:0]        wr_data;
    logic [HOLD_W-1:0] wr_hold;
    logic [AW:0]       len;
    logic              start;
    logic              abort;
    logic              loop;
    logic              a;
    logic              b;
    logic              busy;
    logic              done;
    logic [AW-1:0]     step_idx;
    modport master (
        output wr_en, wr_addr, wr_data, wr_hold, len, start, abort, loop,
        input  a, b, busy, done, step_idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_hold, len, start, abort, loop,
        output a, b, busy, done, step_idx
    );
endinterface

// File: rtl/ab_pattern_gen.sv
// ab_pattern_gen: plays a loadable table of {a,b} steps, each held for hold+1 cycles
// clk, rst_n : rising-edge clock, synchronous active-low reset (also clears the table)
// bus        : slave side of ab_pattern_gen_if (table writes, len/start/abort/loop, a/b/busy/done/step_idx)
module ab_pattern_gen #(
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    ab_pattern_gen_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = HOLD_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_n;
    logic [EW-1:0]     tbl [DEPTH];
    logic [1:0]        ab_q, ab_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [AW-1:0]     idx_q, idx_n, ld_idx;
    logic [LW-1:0]     eff_len_q, eff_len_n;
    logic              done_q, done_n;
    logic              run, adv, last, go, ending, load;
    logic [EW-1:0]     entry;

    assign run    = state_q == RUN;
    assign adv    = hold_q == '0;
    assign last   = LW'(idx_q) + LW'(1) == eff_len_q;
    assign go     = !run && bus.start && !bus.abort && bus.len != '0;
    assign ending = run && adv && last && !bus.loop && !bus.abort;
    // a step entry is fetched on start and on every advance that does not end the run
    assign load   = go || (run && adv && !bus.abort && !ending);
    assign ld_idx = (go || last) ? '0 : idx_q + AW'(1);
    assign entry  = tbl[ld_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (bus.abort)   state_n = IDLE;
        else if (go)     state_n = RUN;
        else if (ending) state_n = IDLE;
    end

    always_comb begin
        ab_n      = load ? entry[EW-1:HOLD_W] : (state_n == IDLE) ? 2'b00 : ab_q;
        hold_n    = load ? entry[HOLD_W-1:0] : (run && !adv) ? hold_q - HOLD_W'(1) : hold_q;
        idx_n     = load ? ld_idx : (state_n == IDLE) ? '0 : idx_q;
        done_n    = ending;
        eff_len_n = go ? ((bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len) : eff_len_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ab_q      <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            eff_len_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            ab_q      <= ab_n;
            hold_q    <= hold_n;
            idx_q     <= idx_n;
            eff_len_q <= eff_len_n;
            done_q    <= done_n;
            // table is frozen while a run is in progress
            if (!run && bus.wr_en) tbl[bus.wr_addr] <= {bus.wr_data, bus.wr_hold};
        end
    end

    assign bus.a        = ab_q[1];
    assign bus.b        = ab_q[0];
    assign bus.busy     = run;
    assign bus.done     = done_q;
    assign bus.step_idx = idx_q;
endmodule

// File: doc/ab_pattern_gen.md
# ab_pattern_gen

Synthesizable, programmable stimulus generator that drives a two-bit signal pair (`a`, `b`) from a small loadable step table. Each step holds a value for a programmable number of cycles. This is the driving side of the `a`/`b` checker environment. Assertion checkers such as the unknown-value and one-hot properties observe these outputs. Every output therefore carries a defined value at all times after reset, and no output can ever be X.

## Interface
Parameters:
- `DEPTH`, default 16: number of step table entries (power of 2, ≥2).
- `HOLD_W`, default 4: width of the per-step hold field. A step lasts hold+1 cycles.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `wr_en`, input, 1: writes one table entry this cycle.
- `wr_addr`, input, $clog2(DEPTH): table index to write.
- `wr_data`, input, 2: step value. Bit 1 drives `a`; bit 0 drives `b`.
- `wr_hold`, input, HOLD_W: step duration minus one.
- `len`, input, $clog2(DEPTH)+1: number of valid steps. Sampled at start.
- `start`, input, 1: begins a run. Level-sampled, acted on only in IDLE.
- `abort`, input, 1: terminates a run immediately.
- `loop`, input, 1: repeat the sequence. Sampled at each wrap point.
- `a`, output, 1: pattern bit 1.
- `b`, output, 1: pattern bit 0.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse on normal (non-aborted) completion.
- `step_idx`, output, $clog2(DEPTH): index of the step currently driven.

## Operation
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `a`=0, `b`=0, `busy`=0, `done`=0, `step_idx`=0.
  - The table is cleared to value 0, hold 0.
- States are IDLE and RUN.
- IDLE:
  - Outputs `a`/`b` are held at 0.
  - `wr_en` writes `{wr_data, wr_hold}` to `wr_addr`.
  - If `start`=1 and `abort`=0 and `len`≠0, the block latches `eff_len` = min(`len`, DEPTH) and enters RUN.
  - On that same edge, entry 0 is loaded: `a`/`b` take the entry value, the hold counter takes the entry hold, `step_idx`=0, and `busy`=1.
  - `start` with `len`=0 is ignored: no state change and no `done`.
- RUN:
  - Each edge with hold counter ≠0 decrements the counter; outputs are unchanged.
  - When the hold counter is 0, the block advances:
    - If `step_idx` < `eff_len`-1, it loads entry `step_idx`+1.
    - Else, if `loop`=1, it loads entry 0.
    - Else, it returns to IDLE with `a`=`b`=0, `busy`=0, and `done`=1 for one cycle.
- `wr_en` in RUN is ignored; the table is frozen during a run.
- `start` in RUN is ignored.
- `abort`=1 in any state at an edge:
  - The next state is IDLE with `a`=`b`=0, `busy`=0, `step_idx`=0.
  - `done` stays 0.
  - Abort takes priority over `start` and over step advance.
- `loop` deasserted mid-pass: the current pass completes, and the run ends at the next wrap.
- `len` changes in RUN have no effect; `eff_len` was latched at start.

## Timing
- Start latency: `start` sampled high at edge N → first step value visible on `a`/`b` after edge N, i.e. from cycle N+1.
- Step k is driven for exactly hold_k+1 cycles. There are no gap cycles between steps or across a loop wrap.
- A non-looping run occupies sum over k of (hold_k+1) cycles with `busy`=1.
- `done` is asserted in the first cycle after the last step, coincident with `a`=`b`=0 and `busy`=0.
- A new `start` is accepted in the `done` cycle, giving back-to-back runs with one idle cycle between them.
- Abort latency: `abort` sampled at edge N → outputs are 0 from cycle N+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-run behaves identically to abort, and additionally clears the table.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 edges, then release → `a`=`b`=`busy`=`done`=0 and `step_idx`=0, with no X on any output from the first post-reset edge.
- **Basic run:** write entry 0 = {10, hold 0}, entry 1 = {01, hold 1}, entry 2 = {11, hold 0}; `len`=3, `loop`=0; pulse `start` at edge 0 → `a`,`b` = 1,0 / 0,1 / 0,1 / 1,1 over cycles 1–4. Cycle 5: `a`=`b`=0, `done`=1, `busy`=0. Cycle 6: `done`=0.
- **Loop:** same table with `loop`=1 → the pattern repeats with no gap cycles (cycle 5 = 1,0). Drop `loop` during the second pass → `done` fires after that pass only.
- **Abort:** start a run with `loop`=1, assert `abort` together with `start` at cycle 3 → `a`=`b`=0 and `busy`=0 from cycle 4, `done` never asserts, and the new `start` is ignored.
- **Boundaries:**
  - `len`=0 with `start` → no activity.
  - `len`=DEPTH+5 → exactly DEPTH steps are played.
  - `wr_en` during RUN → on a rerun, the old entry values are observed.
- **X-check:** assert `!$isunknown({a,b,busy,done})` at every `posedge clk` after reset, across all of the above scenarios → zero failures.
